// File: rtl/ex_op_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ex_op_sched
//  Purpose  : Single-in-flight execute scheduler. Accepts one operation,
//             pulses ex_en to the datapath, waits LAT cycles, captures the
//             ALU result and holds it until the consumer accepts it.
//  Options  : EX_SCHED_B2B_EN - when defined, a new request can be taken in
//             DONE in the same cycle the response is consumed, skipping IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module ex_op_sched #(
  parameter int LAT  = 2,   // legal range 1..15
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_cntrl,
  input  logic [TAGW-1:0] req_tag,
  output logic            ex_en,
  output logic [6:0]      ex_cntrl,
  input  logic [31:0]     alu_result,
  input  logic            alu_carry,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_carry,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // WAIT runs while the counter walks from LAT-1 down to 0, i.e. LAT cycles.
  localparam logic [3:0] c_CNT_LOAD = 4'(LAT - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [3:0]      r_cnt;
  logic [6:0]      r_cntrl;
  logic [TAGW-1:0] r_tag;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_carry;
  logic [TAGW-1:0] r_rsp_tag;
  logic            w_b2b_ok;
  logic            w_accept;
  logic            w_cnt_zero;

`ifdef EX_SCHED_B2B_EN
  // A response being consumed frees the slot in the same cycle.
  assign w_b2b_ok = (r_state == c_DONE) & rsp_ready;
`else
  assign w_b2b_ok = 1'b0;
`endif

  // req_ready depends only on state and rsp_ready, never on req_valid.
  assign req_ready  = (r_state == c_IDLE) | w_b2b_ok;
  assign w_accept   = req_valid & req_ready;
  assign w_cnt_zero = (r_cnt == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (req_valid) w_state_nxt = c_ISSUE;
      c_ISSUE: w_state_nxt = c_WAIT;
      c_WAIT:  if (w_cnt_zero) w_state_nxt = c_DONE;
      c_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = (w_b2b_ok & req_valid) ? c_ISSUE : c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    ex_en     = 1'b0;
    ex_cntrl  = 7'd0;
    rsp_valid = 1'b0;
    busy      = (r_state != c_IDLE);
    case (r_state)
      c_ISSUE: begin
        ex_en    = 1'b1;
        ex_cntrl = r_cntrl;
      end
      c_WAIT:  ex_cntrl = r_cntrl;
      c_DONE:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, latency counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_cntrl     <= 7'd0;
      r_tag       <= '0;
      r_rsp_data  <= 32'd0;
      r_rsp_carry <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      if (w_accept) begin
        r_cntrl <= req_cntrl;
        r_tag   <= req_tag;
      end
      if (r_state == c_ISSUE) begin
        r_cnt <= c_CNT_LOAD;
      end else if ((r_state == c_WAIT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Response registers only change on capture, so they stay stable
      // for the whole DONE period regardless of alu_result activity.
      if ((r_state == c_WAIT) && w_cnt_zero) begin
        r_rsp_data  <= alu_result;
        r_rsp_carry <= alu_carry;
        r_rsp_tag   <= r_tag;
      end
    end
  end

  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_tag   = r_rsp_tag;

endmodule
`default_nettype wire

// File: tb/tb_ex_op_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_op_sched
//  Purpose  : Bench for ex_op_sched; three instances (LAT = 1, 2, 4) share
//             one stimulus stream and are each tracked by a transaction-level
//             model built from accept time and latency arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_op_sched;

`ifdef EX_SCHED_B2B_EN
  localparam bit c_B2B = 1'b1;
`else
  localparam bit c_B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [6:0]  req_cntrl;
  logic [3:0]  req_tag;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        rsp_ready;

  logic [2:0]  req_ready_w, ex_en_w, rsp_valid_w, rsp_carry_w, busy_w;
  logic [6:0]  ex_cntrl_w [3];
  logic [31:0] rsp_data_w [3];
  logic [3:0]  rsp_tag_w  [3];

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // One instance per latency, each with its own reference model
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

    ex_op_sched #(.LAT(L), .TAGW(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready_w[gi]),
      .req_cntrl  (req_cntrl),
      .req_tag    (req_tag),
      .ex_en      (ex_en_w[gi]),
      .ex_cntrl   (ex_cntrl_w[gi]),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .rsp_valid  (rsp_valid_w[gi]),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data_w[gi]),
      .rsp_carry  (rsp_carry_w[gi]),
      .rsp_tag    (rsp_tag_w[gi]),
      .busy       (busy_w[gi])
    );

    // Model: an op accepted in cycle A issues in A+1, captures at the end
    // of cycle A+L+1 and presents its response from A+L+2 until consumed.
    bit          m_infl, m_done;
    int          m_acc;
    logic [6:0]  m_cntrl;
    logic [3:0]  m_tag, m_rtag;
    logic [31:0] m_rdata;
    logic        m_rcarry;

    always @(negedge clk) begin : p_model
      bit         idle, e_ready, e_en;
      logic [6:0] e_cntrl;
      idle    = !m_infl && !m_done;
      e_ready = idle || (c_B2B && m_done && rsp_ready);
      e_en    = m_infl && (cyc == m_acc + 1);
      e_cntrl = m_infl ? m_cntrl : 7'd0;
      if (chk_en) begin
        check($sformatf("u%0d_req_ready", gi), 32'(req_ready_w[gi]), 32'(e_ready));
        check($sformatf("u%0d_ex_en", gi),     32'(ex_en_w[gi]),     32'(e_en));
        check($sformatf("u%0d_ex_cntrl", gi),  32'(ex_cntrl_w[gi]),  32'(e_cntrl));
        check($sformatf("u%0d_busy", gi),      32'(busy_w[gi]),      32'(!idle));
        check($sformatf("u%0d_rsp_valid", gi), 32'(rsp_valid_w[gi]), 32'(m_done));
        check($sformatf("u%0d_rsp_data", gi),  rsp_data_w[gi],       m_rdata);
        check($sformatf("u%0d_rsp_carry", gi), 32'(rsp_carry_w[gi]), 32'(m_rcarry));
        check($sformatf("u%0d_rsp_tag", gi),   32'(rsp_tag_w[gi]),   32'(m_rtag));
      end
      if (rst) begin
        m_infl = 0; m_done = 0; m_acc = 0; m_cntrl = '0; m_tag = '0;
        m_rtag = '0; m_rdata = '0; m_rcarry = 1'b0;
      end else begin
        if (m_done && rsp_ready) m_done = 0;
        if (m_infl && (cyc == m_acc + L + 1)) begin
          m_rdata = alu_result; m_rcarry = alu_carry; m_rtag = m_tag;
          m_infl = 0; m_done = 1;
        end
        if (req_valid && e_ready) begin
          m_infl = 1; m_acc = cyc; m_cntrl = req_cntrl; m_tag = req_tag;
        end
      end
    end
  end

  // Advance to just after the next rising edge with fresh ALU noise
  task automatic tick();
    @(posedge clk);
    #1;
    alu_result = $urandom;
    alu_carry  = 1'($urandom);
  endtask

  task automatic drain(input int n);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  int en_cyc[$];
  int rtags[$];
  int nxt;
  bit accepted, seen;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cntrl = '0; req_tag = '0;
    alu_result = '0; alu_carry = 1'b0; rsp_ready = 1'b0;

    // ---- reset then idle ----
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready_w[1]), 32'd1);
      check("idle_busy",      32'(busy_w[1]),      32'd0);
      check("idle_rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
      check("idle_ex_en",     32'(ex_en_w[1]),     32'd0);
      check("idle_rsp_data",  rsp_data_w[1],       32'd0);
      tick();
    end

    // ---- single op on LAT=2, then backpressure ----
    req_valid = 1'b1; req_cntrl = 7'h15; req_tag = 4'd3; rsp_ready = 1'b0;
    @(negedge clk); check("op_accept_ready", 32'(req_ready_w[1]), 32'd1);
    tick(); req_valid = 1'b0;
    @(negedge clk);
    check("op_c1_ex_en",    32'(ex_en_w[1]),    32'd1);
    check("op_c1_ex_cntrl", 32'(ex_cntrl_w[1]), 32'h15);
    tick();
    @(negedge clk);
    check("op_c2_ex_en",    32'(ex_en_w[1]),    32'd0);
    check("op_c2_ex_cntrl", 32'(ex_cntrl_w[1]), 32'h15);
    tick(); alu_result = 32'hDEADBEEF; alu_carry = 1'b1;
    @(negedge clk);
    check("op_c3_rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
    check("op_c3_ex_cntrl",  32'(ex_cntrl_w[1]),  32'h15);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid_w[1]), 32'd1);
      check("bp_rsp_data",  rsp_data_w[1],       32'hDEADBEEF);
      check("bp_rsp_carry", 32'(rsp_carry_w[1]), 32'd1);
      check("bp_rsp_tag",   32'(rsp_tag_w[1]),   32'd3);
      check("bp_ex_en",     32'(ex_en_w[1]),     32'd0);
      check("bp_req_ready", 32'(req_ready_w[1]), 32'd0);
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk); check("bp_release_valid", 32'(rsp_valid_w[1]), 32'd1);
    tick();
    @(negedge clk); check("bp_after_valid", 32'(rsp_valid_w[1]), 32'd0);
    drain(10);

    // ---- back-to-back on LAT=1, tags 1,2,3 ----
    nxt = 1; req_valid = 1'b1; req_tag = 4'd1; req_cntrl = 7'h2A; rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ex_en_w[0]) en_cyc.push_back(c);
      if (rsp_valid_w[0]) rtags.push_back(int'(rsp_tag_w[0]));
      accepted = req_valid && req_ready_w[0];
      tick();
      if (accepted) begin
        if (nxt == 3) req_valid = 1'b0;
        else begin nxt++; req_tag = 4'(nxt); end
      end
      if (rtags.size() == 3) break;
    end
    check("b2b_en_count",  32'(en_cyc.size()), 32'd3);
    check("b2b_rsp_count", 32'(rtags.size()),  32'd3);
    if (en_cyc.size() >= 3) begin
      check("b2b_gap1", 32'(en_cyc[1] - en_cyc[0]), c_B2B ? 32'd3 : 32'd4);
      check("b2b_gap2", 32'(en_cyc[2] - en_cyc[1]), c_B2B ? 32'd3 : 32'd4);
    end
    for (int i = 0; i < rtags.size(); i++)
      check("b2b_tag_order", 32'(rtags[i]), 32'(i + 1));
    drain(12);

    // ---- reset mid-WAIT on LAT=4 ----
    req_valid = 1'b1; req_tag = 4'd7; req_cntrl = 7'h33;
    tick(); req_valid = 1'b0;
    @(negedge clk); check("rw_ex_en", 32'(ex_en_w[2]), 32'd1);
    tick(); tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rw_busy",      32'(busy_w[2]),      32'd0);
    check("rw_req_ready", 32'(req_ready_w[2]), 32'd1);
    check("rw_ex_cntrl",  32'(ex_cntrl_w[2]),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (rsp_valid_w[2]) seen = 1'b1;
      tick();
    end
    check("rw_no_rsp", 32'(seen), 32'd0);
    req_valid = 1'b1; req_tag = 4'd5;
    tick(); req_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("rw_new_valid", 32'(rsp_valid_w[2]), 32'd1);
    check("rw_new_tag",   32'(rsp_tag_w[2]),   32'd5);
    drain(4);

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_cntrl = 7'($urandom);
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    drain(3);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
